wb_pack_engine: RTL and testbench

Parametrised writeback engine. It sums NUM_TERMS signed partial sums per lane for NUM_LANES lanes, applies optional ReLU, saturates each result to OUT_W bits, and packs the results MSB-byte-first into WORD_W-bit words. Each completed word is written to the 32k activation BRAM, one port per lane. Compared with the fixed two-lane Layer1 writer it adds run/flush control, partial-word flush, a per-layer base address, ReLU and a ready/valid input.

---
 rtl/wb_pack_engine_pkg.sv | 19 +
 rtl/wb_sat_relu.sv | 30 +++
 rtl/wb_pack_engine.sv | 149 ++++++++++++++
 tb/tb_wb_pack_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pack_engine_pkg.sv
// Shared types and helpers for the activation writeback engine.
// Reset level, FSM encoding and adder-tree width rule.
package wb_pack_engine_pkg;

  localparam logic RST_ACT = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FLUSH_WR,
    S_DONE
  } state_t;

  function automatic int sum_w(input int in_w, input int terms);
    return in_w + $clog2(terms);
  endfunction

endpackage

// File: rtl/wb_sat_relu.sv
// Combinational ReLU followed by signed saturation to OUT_W bits.
// One instance per lane sits between the adder tree and the packer.
module wb_sat_relu
  import wb_pack_engine_pkg::*;
#(
  parameter int IN_W  = 13,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0] x,
  input  logic                   relu_en,
  output logic [OUT_W-1:0]       y
);

  localparam logic signed [IN_W-1:0] MAXV = IN_W'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W-1:0] MINV = ~MAXV;

  logic signed [IN_W-1:0] v;

  always_comb begin
    v = (relu_en && x[IN_W-1]) ? '0 : x;
    if (v > MAXV) begin
      y = MAXV[OUT_W-1:0];
    end else if (v < MINV) begin
      y = MINV[OUT_W-1:0];
    end else begin
      y = v[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/wb_pack_engine.sv
// Multi-lane writeback: adder tree, ReLU/saturate, byte packer and
// BRAM word writer with run/flush control.
module wb_pack_engine
  import wb_pack_engine_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int NUM_TERMS   = 5,
  parameter int IN_W        = 10,
  parameter int OUT_W       = 8,
  parameter int WORD_W      = 64,
  parameter int ADDR_W      = 12,
  parameter int LANE_STRIDE = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic                           relu_en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANES*NUM_TERMS*IN_W-1:0] sum_in,
  input  logic                           flush,
  output logic                           we,
  output logic [NUM_LANES*ADDR_W-1:0]    addr,
  output logic [NUM_LANES*WORD_W-1:0]    din,
  output logic                           done,
  output logic [ADDR_W-1:0]              word_cnt
);

  localparam int BPW    = WORD_W / OUT_W;
  localparam int SW     = sum_w(IN_W, NUM_TERMS);
  localparam int SLOT_W = $clog2(BPW);
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(BPW - 1);

  state_t state, state_nxt;
  logic   drain_cnt;
  logic   hs, go, s1_valid, full, relu_q, wr_part;
  logic [ADDR_W-1:0]           base_q;
  logic [SLOT_W-1:0]           slot_cnt;
  logic [NUM_LANES*SW-1:0]     s1_d, s1_q;
  logic [NUM_LANES*WORD_W-1:0] pack_d, pack_q;

  assign hs      = in_valid & in_ready;
  assign go      = (state == S_IDLE) & start;
  assign wr_part = (state == S_FLUSH_WR) && (slot_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      S_IDLE:     if (start) state_nxt = S_RUN;
      S_RUN: begin
        in_ready = 1'b1;
        if (flush) state_nxt = S_DRAIN;
      end
      S_DRAIN:    if (drain_cnt) state_nxt = S_FLUSH_WR;
      S_FLUSH_WR: state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic signed [SW-1:0] acc;
    logic [OUT_W-1:0]     res;
    logic [WORD_W-1:0]    word;

    always_comb begin
      acc = '0;
      for (int t = 0; t < NUM_TERMS; t++) begin
        acc = acc + SW'($signed(sum_in[(l*NUM_TERMS+t)*IN_W +: IN_W]));
      end
    end

    assign s1_d[l*SW +: SW] = acc;

    wb_sat_relu #(.IN_W(SW), .OUT_W(OUT_W)) u_sat (
      .x       (s1_q[l*SW +: SW]),
      .relu_en (relu_q),
      .y       (res)
    );

    // Slot 0 starts a fresh word, so a completed word never leaks forward.
    always_comb begin
      word = (slot_cnt == '0) ? '0 : pack_q[l*WORD_W +: WORD_W];
      word[(BPW-1-int'(slot_cnt))*OUT_W +: OUT_W] = res;
    end

    assign pack_d[l*WORD_W +: WORD_W] = word;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      we       <= 1'b0;
      done     <= 1'b0;
      addr     <= '0;
      din      <= '0;
      word_cnt <= '0;
      s1_valid <= 1'b0;
      s1_q     <= '0;
      pack_q   <= '0;
      slot_cnt <= '0;
      full     <= 1'b0;
      relu_q   <= 1'b0;
      base_q   <= '0;
    end else begin
      we       <= 1'b0;
      done     <= (state == S_DONE);
      s1_valid <= hs;
      full     <= s1_valid && (slot_cnt == LAST);
      if (hs) s1_q <= s1_d;
      if (s1_valid) begin
        pack_q   <= pack_d;
        slot_cnt <= (slot_cnt == LAST) ? '0 : slot_cnt + SLOT_W'(1);
      end
      if (full || wr_part) begin
        we       <= 1'b1;
        din      <= pack_q;
        word_cnt <= word_cnt + ADDR_W'(1);
        for (int k = 0; k < NUM_LANES; k++) begin
          addr[k*ADDR_W +: ADDR_W] <=
            base_q + ADDR_W'(k*LANE_STRIDE) + word_cnt;
        end
      end
      if (state == S_FLUSH_WR) begin
        slot_cnt <= '0;
        pack_q   <= '0;
      end
      if (go) begin
        base_q   <= base_addr;
        relu_q   <= relu_en;
        word_cnt <= '0;
        slot_cnt <= '0;
        pack_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_pack_engine.sv
// Directed bench for wb_pack_engine: single-result vector table plus
// hand-written multi-cycle sequences (pack, stream, flush, reset).
module tb_wb_pack_engine;

  localparam int NL = 2;
  localparam int NT = 5;
  localparam int IW = 10;
  localparam int WW = 64;
  localparam int AW = 12;

  logic clk = 0;
  logic rst = 0;
  logic start = 0;
  logic relu_en = 0;
  logic in_valid = 0;
  logic flush = 0;
  logic [AW-1:0] base_addr = '0;
  logic [NL*NT*IW-1:0] sum_in = '0;
  logic in_ready, we, done;
  logic [NL*AW-1:0] addr;
  logic [NL*WW-1:0] din;
  logic [AW-1:0] word_cnt;

  wb_pack_engine dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .flush(flush), .we(we), .addr(addr), .din(din),
    .done(done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               c;
    logic [NL*AW-1:0] a;
    logic [NL*WW-1:0] d;
  } wr_t;

  wr_t wq[$];
  int  done_n = 0;
  int  done_cyc = 0;

  always @(negedge clk) begin
    if (we) wq.push_back('{cyc, addr, din});
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  int checks = 0;
  int errors = 0;
  int hs_cyc = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_wr(input int i, input string name,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [WW-1:0] d0, input logic [WW-1:0] d1);
    if (i < wq.size()) begin
      chk({name, "_addr"}, wq[i].a, {a1, a0});
      chk({name, "_din0"}, wq[i].d[WW-1:0], d0);
      chk({name, "_din1"}, wq[i].d[2*WW-1:WW], d1);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s write %0d missing, have %0d", name, i, wq.size());
    end
  endtask

  function automatic logic [NL*NT*IW-1:0] mk(input int f0, input int r0,
                                            input int f1, input int r1);
    logic [NL*NT*IW-1:0] s;
    s = '0;
    for (int t = 0; t < NT; t++) begin
      s[t*IW +: IW]      = IW'((t == 0) ? f0 : r0);
      s[(NT+t)*IW +: IW] = IW'((t == 0) ? f1 : r1);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic r);
    base_addr = b;
    relu_en   = r;
    start     = 1;
    tick();
    start     = 0;
  endtask

  task automatic push(input int f0, input int r0, input int f1, input int r1);
    sum_in   = mk(f0, r0, f1, r1);
    in_valid = 1;
    chk("in_ready_run", in_ready, 1);
    hs_cyc = cyc;
    tick();
    in_valid = 0;
  endtask

  task automatic pulse_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic wait_done(input int lim);
    int n0;
    int k;
    n0 = done_n;
    k = 0;
    while (done_n == n0 && k < lim) begin
      tick();
      k++;
    end
    chk("done_seen", done_n != n0, 1);
    tick();
  endtask

  typedef struct {
    int         f0, r0, f1, r1;
    logic       relu;
    logic [7:0] e0, e1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 1, -1, -1, 1'b0, 8'h05, 8'hFB};
    tbl[1] = '{511, 511, -512, -512, 1'b0, 8'h7F, 8'h80};
    tbl[2] = '{511, 511, -512, -512, 1'b1, 8'h7F, 8'h00};
    tbl[3] = '{25, 25, -25, -25, 1'b0, 8'h7D, 8'h83};
    tbl[4] = '{127, 0, -128, 0, 1'b0, 8'h7F, 8'h80};
    tbl[5] = '{128, 0, -129, 0, 1'b0, 8'h7F, 8'h80};
    tbl[6] = '{-30, -30, 5, 5, 1'b0, 8'h80, 8'h19};
    tbl[7] = '{0, -1, 100, -25, 1'b1, 8'h00, 8'h00};
    tbl[8] = '{10, 10, -1, 0, 1'b1, 8'h32, 8'h00};
    tbl[9] = '{3, -1, -100, -7, 1'b0, 8'hFF, 8'h80};

    tick();
    tick();
    chk("rst_we", we, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_addr", addr, 0);
    chk("rst_din", din, 0);
    rst = 1;
    tick();

    for (int i = 0; i < 10; i++) begin
      wq.delete();
      do_start(AW'(12'h100 + 16*i), tbl[i].relu);
      push(tbl[i].f0, tbl[i].r0, tbl[i].f1, tbl[i].r1);
      pulse_flush();
      wait_done(20);
      chk("vec_nwr", wq.size(), 1);
      chk_wr(0, $sformatf("vec%0d", i), AW'(12'h100 + 16*i),
             AW'(12'h180 + 16*i), {tbl[i].e0, 56'h0}, {tbl[i].e1, 56'h0});
    end

    wq.delete();
    do_start(12'h000, 1'b0);
    for (int v = 1; v <= 8; v++) push(v, v, -v, -v);
    repeat (6) tick();
    chk("pack_nwr", wq.size(), 1);
    chk_wr(0, "pack", 12'd0, 12'd128, 64'h050A0F14191E2328,
           64'hFBF6F1ECE7E2DDD8);
    if (wq.size() > 0) chk("pack_latency", wq[0].c - hs_cyc, 3);
    pulse_flush();
    wait_done(20);
    chk("pack_nwr_after_flush", wq.size(), 1);
    chk("pack_word_cnt", word_cnt, 1);

    wq.delete();
    do_start(12'h000, 1'b0);
    for (int v = 0; v < 3; v++) push(1, 0, 1, 0);
    pulse_flush();
    wait_done(20);
    chk("part_nwr", wq.size(), 1);
    chk_wr(0, "part", 12'd0, 12'd128, 64'h0101010000000000,
           64'h0101010000000000);
    if (wq.size() > 0) chk("part_done_lag", done_cyc - wq[0].c, 1);
    chk("part_idle_ready", in_ready, 0);
    chk("part_word_cnt", word_cnt, 1);

    wq.delete();
    do_start(12'hFFE, 1'b0);
    for (int i = 0; i < 64; i++)
      push((i/8)+1, (i/8)+1, -((i/8)+1), -((i/8)+1));
    pulse_flush();
    wait_done(30);
    chk("strm_nwr", wq.size(), 8);
    for (int w = 0; w < 8; w++) begin
      chk_wr(w, $sformatf("strm%0d", w), AW'(12'hFFE + w),
             AW'(12'hFFE + 128 + w), {8{8'(5*(w+1))}}, {8{8'(-5*(w+1))}});
      if (w > 0 && w < wq.size())
        chk("strm_spacing", wq[w].c - wq[w-1].c, 8);
    end
    chk("strm_word_cnt", word_cnt, 8);

    wq.delete();
    do_start(12'h020, 1'b0);
    base_addr = 12'h300;
    start = 1;
    for (int k = 1; k <= 7; k++) push(k, 0, -k, 0);
    start = 0;
    flush = 1;
    push(8, 0, -8, 0);
    flush = 0;
    wait_done(20);
    chk("coin_nwr", wq.size(), 1);
    chk_wr(0, "coin", 12'h020, 12'h0A0, 64'h0102030405060708,
           64'hFFFEFDFCFBFAF9F8);
    chk("coin_word_cnt", word_cnt, 1);

    wq.delete();
    do_start(12'h050, 1'b0);
    pulse_flush();
    wait_done(20);
    chk("empty_nwr", wq.size(), 0);
    chk("empty_word_cnt", word_cnt, 0);
    begin
      int n0;
      n0 = done_n;
      pulse_flush();
      repeat (6) tick();
      chk("idle_flush_ignored", done_n - n0, 0);
      chk("idle_ready", in_ready, 0);
    end

    wq.delete();
    do_start(12'h040, 1'b0);
    for (int k = 0; k < 4; k++) push(9, 0, 9, 0);
    rst = 0;
    tick();
    chk("mid_rst_we", we, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_din", din, 0);
    chk("mid_rst_done", done, 0);
    rst = 1;
    tick();
    wq.delete();
    do_start(12'h040, 1'b0);
    for (int k = 0; k < 8; k++) push(2, 0, 2, 0);
    repeat (5) tick();
    chk("post_rst_nwr", wq.size(), 1);
    chk_wr(0, "post_rst", 12'h040, 12'h0C0, 64'h0202020202020202,
           64'h0202020202020202);
    chk("post_rst_word_cnt", word_cnt, 1);
    pulse_flush();
    wait_done(20);
    chk("post_rst_nwr_end", wq.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
